// File: rtl/exu_disp_oitf_pkg.sv
// Shared widths and hazard bundle for the dispatch stage and its
// outstanding-instruction-track FIFO.
package exu_disp_oitf_pkg;
  localparam int XLEN          = 32;
  localparam int PC_SIZE       = 32;
  localparam int RFIDX_WIDTH   = 5;
  localparam int DECINFO_WIDTH = 32;
  localparam int OITF_DEPTH    = 4;
  localparam int ITAG_WIDTH    = $clog2(OITF_DEPTH);

  typedef struct packed {
    logic raw1;
    logic raw2;
    logic waw;
    logic full;
  } hazard_t;

  function automatic logic any_hazard(input hazard_t h);
    return h.raw1 | h.raw2 | h.waw | h.full;
  endfunction
endpackage

// File: rtl/exu_disp_oitf_if.sv
// Dispatch, ALU issue and long-pipe retire signal bundle.
interface exu_disp_oitf_if #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RFIDX_W = 5,
  parameter int INFO_W  = 32,
  parameter int ITAG_W  = 2
) ();
  logic               disp_i_valid;
  logic               disp_i_ready;
  logic               disp_i_rs1x0;
  logic               disp_i_rs2x0;
  logic               disp_i_rs1en;
  logic               disp_i_rs2en;
  logic [RFIDX_W-1:0] disp_i_rs1idx;
  logic [RFIDX_W-1:0] disp_i_rs2idx;
  logic [XLEN-1:0]    disp_i_rs1;
  logic [XLEN-1:0]    disp_i_rs2;
  logic               disp_i_rdwen;
  logic [RFIDX_W-1:0] disp_i_rdidx;
  logic [INFO_W-1:0]  disp_i_info;
  logic [XLEN-1:0]    disp_i_imm;
  logic [PC_W-1:0]    disp_i_pc;

  logic               disp_o_alu_valid;
  logic               disp_o_alu_ready;
  logic               disp_o_alu_longpipe;
  logic [XLEN-1:0]    disp_o_alu_rs1;
  logic [XLEN-1:0]    disp_o_alu_rs2;
  logic               disp_o_alu_rdwen;
  logic [RFIDX_W-1:0] disp_o_alu_rdidx;
  logic [INFO_W-1:0]  disp_o_alu_info;
  logic [XLEN-1:0]    disp_o_alu_imm;
  logic [PC_W-1:0]    disp_o_alu_pc;
  logic [ITAG_W-1:0]  disp_o_alu_itag;

  logic               oitf_ret_valid;
  logic               oitf_ret_ready;
  logic [ITAG_W-1:0]  oitf_ret_ptr;
  logic               oitf_ret_rdwen;
  logic [RFIDX_W-1:0] oitf_ret_rdidx;
  logic               oitf_empty;
  logic               oitf_full;

  modport master (
    output disp_i_valid, disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en,
           disp_i_rs1idx, disp_i_rs2idx, disp_i_rs1, disp_i_rs2, disp_i_rdwen,
           disp_i_rdidx, disp_i_info, disp_i_imm, disp_i_pc,
           disp_o_alu_ready, disp_o_alu_longpipe, oitf_ret_valid,
    input  disp_i_ready, disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2,
           disp_o_alu_rdwen, disp_o_alu_rdidx, disp_o_alu_info, disp_o_alu_imm,
           disp_o_alu_pc, disp_o_alu_itag, oitf_ret_ready, oitf_ret_ptr,
           oitf_ret_rdwen, oitf_ret_rdidx, oitf_empty, oitf_full
  );

  modport slave (
    input  disp_i_valid, disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en,
           disp_i_rs1idx, disp_i_rs2idx, disp_i_rs1, disp_i_rs2, disp_i_rdwen,
           disp_i_rdidx, disp_i_info, disp_i_imm, disp_i_pc,
           disp_o_alu_ready, disp_o_alu_longpipe, oitf_ret_valid,
    output disp_i_ready, disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2,
           disp_o_alu_rdwen, disp_o_alu_rdidx, disp_o_alu_info, disp_o_alu_imm,
           disp_o_alu_pc, disp_o_alu_itag, oitf_ret_ready, oitf_ret_ptr,
           oitf_ret_rdwen, oitf_ret_rdidx, oitf_empty, oitf_full
  );
endinterface

// File: rtl/exu_disp_oitf_oitf.sv
// In-order tracker of outstanding long-pipe writes: entries, wrap-bit
// pointers, full/empty flags and register-index match vectors.
module exu_oitf
  import exu_disp_oitf_pkg::*;
#(
  parameter int OITF_DEPTH = exu_disp_oitf_pkg::OITF_DEPTH,
  parameter int ITAG_W     = $clog2(OITF_DEPTH),
  parameter int RFIDX_W    = RFIDX_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alloc,
  input  logic               i_alloc_rdwen,
  input  logic [RFIDX_W-1:0] i_alloc_rdidx,
  input  logic               i_ret_valid,
  input  logic [RFIDX_W-1:0] i_rs1idx,
  input  logic [RFIDX_W-1:0] i_rs2idx,
  input  logic [RFIDX_W-1:0] i_rdidx,
  output logic [ITAG_W-1:0]  o_wr_ptr,
  output logic [ITAG_W-1:0]  o_ret_ptr,
  output logic               o_ret_rdwen,
  output logic [RFIDX_W-1:0] o_ret_rdidx,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_oitfrd_match_rs1,
  output logic               o_oitfrd_match_rs2,
  output logic               o_oitfrd_match_rd
);
  localparam logic [ITAG_W-1:0] LAST = ITAG_W'(OITF_DEPTH - 1);

  logic [ITAG_W-1:0]     r_wr_ptr;
  logic [ITAG_W-1:0]     r_rd_ptr;
  logic                  r_wr_flg;
  logic                  r_rd_flg;
  logic [OITF_DEPTH-1:0] r_vld;
  logic [OITF_DEPTH-1:0] r_rdwen;
  logic [RFIDX_W-1:0]    r_rdidx [OITF_DEPTH];

  logic w_ptr_eq;
  logic w_empty;
  logic w_ret;

  assign w_ptr_eq = (r_wr_ptr == r_rd_ptr);
  assign w_empty  = w_ptr_eq & (r_wr_flg == r_rd_flg);
  assign w_ret    = i_ret_valid & ~w_empty;

  // Alloc and retire never target the same slot: that needs full (alloc
  // stalled) or empty (retire ignored).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wr_flg <= 1'b0;
      r_rd_flg <= 1'b0;
      r_vld    <= '0;
    end else begin
      if (w_ret) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        if (r_rd_ptr == LAST) r_rd_flg <= ~r_rd_flg;
      end
      if (i_alloc) begin
        r_vld[r_wr_ptr]   <= 1'b1;
        r_rdwen[r_wr_ptr] <= i_alloc_rdwen;
        r_rdidx[r_wr_ptr] <= i_alloc_rdidx;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == LAST) r_wr_flg <= ~r_wr_flg;
      end
    end
  end

  always_comb begin
    o_oitfrd_match_rs1 = 1'b0;
    o_oitfrd_match_rs2 = 1'b0;
    o_oitfrd_match_rd  = 1'b0;
    for (int k = 0; k < OITF_DEPTH; k++) begin
      if (r_vld[k] && r_rdwen[k]) begin
        if (r_rdidx[k] == i_rs1idx) o_oitfrd_match_rs1 = 1'b1;
        if (r_rdidx[k] == i_rs2idx) o_oitfrd_match_rs2 = 1'b1;
        if (r_rdidx[k] == i_rdidx)  o_oitfrd_match_rd  = 1'b1;
      end
    end
  end

  assign o_wr_ptr    = r_wr_ptr;
  assign o_ret_ptr   = r_rd_ptr;
  assign o_ret_rdwen = r_rdwen[r_rd_ptr];
  assign o_ret_rdidx = r_rdidx[r_rd_ptr];
  assign o_empty     = w_empty;
  assign o_full      = w_ptr_eq & (r_wr_flg != r_rd_flg);
endmodule

// File: rtl/exu_disp_oitf.sv
// EXU dispatch: x0 operand masking, RAW/WAW/full stalling against the OITF,
// and ITAG issue to long-pipe ops.
module exu_disp_oitf
  import exu_disp_oitf_pkg::*;
#(
  parameter int XLEN       = exu_disp_oitf_pkg::XLEN,
  parameter int PC_W       = PC_SIZE,
  parameter int RFIDX_W    = RFIDX_WIDTH,
  parameter int INFO_W     = DECINFO_WIDTH,
  parameter int OITF_DEPTH = exu_disp_oitf_pkg::OITF_DEPTH,
  parameter int ITAG_W     = $clog2(OITF_DEPTH)
) (
  input logic            clk,
  input logic            rst,
  exu_disp_oitf_if.slave io_disp
);
  logic [XLEN-1:0]   w_rs1;
  logic [XLEN-1:0]   w_rs2;
  logic [PC_W-1:0]   w_pc;
  logic [INFO_W-1:0] w_info;
  logic [ITAG_W-1:0] w_wr_ptr;
  logic              w_match_rs1;
  logic              w_match_rs2;
  logic              w_match_rd;
  logic              w_full;
  logic              w_stall;
  logic              w_alu_valid;
  logic              w_alloc;
  hazard_t           w_haz;

  assign w_rs1  = io_disp.disp_i_rs1 & ~{XLEN{io_disp.disp_i_rs1x0}};
  assign w_rs2  = io_disp.disp_i_rs2 & ~{XLEN{io_disp.disp_i_rs2x0}};
  assign w_pc   = io_disp.disp_i_pc;
  assign w_info = io_disp.disp_i_info;

  // Hazards look only at registered OITF state, so a same-cycle retire
  // still stalls for one cycle.
  assign w_haz.raw1 = io_disp.disp_i_rs1en & ~io_disp.disp_i_rs1x0 & w_match_rs1;
  assign w_haz.raw2 = io_disp.disp_i_rs2en & ~io_disp.disp_i_rs2x0 & w_match_rs2;
  assign w_haz.waw  = io_disp.disp_i_rdwen & w_match_rd;
  assign w_haz.full = io_disp.disp_o_alu_longpipe & w_full;
  assign w_stall    = any_hazard(w_haz);

  assign w_alu_valid = io_disp.disp_i_valid & ~w_stall;
  assign w_alloc     = w_alu_valid & io_disp.disp_o_alu_ready & io_disp.disp_o_alu_longpipe;

  exu_oitf #(
    .OITF_DEPTH (OITF_DEPTH),
    .ITAG_W     (ITAG_W),
    .RFIDX_W    (RFIDX_W)
  ) u_oitf (
    .clk                (clk),
    .rst                (rst),
    .i_alloc            (w_alloc),
    .i_alloc_rdwen      (io_disp.disp_i_rdwen),
    .i_alloc_rdidx      (io_disp.disp_i_rdidx),
    .i_ret_valid        (io_disp.oitf_ret_valid),
    .i_rs1idx           (io_disp.disp_i_rs1idx),
    .i_rs2idx           (io_disp.disp_i_rs2idx),
    .i_rdidx            (io_disp.disp_i_rdidx),
    .o_wr_ptr           (w_wr_ptr),
    .o_ret_ptr          (io_disp.oitf_ret_ptr),
    .o_ret_rdwen        (io_disp.oitf_ret_rdwen),
    .o_ret_rdidx        (io_disp.oitf_ret_rdidx),
    .o_empty            (io_disp.oitf_empty),
    .o_full             (w_full),
    .o_oitfrd_match_rs1 (w_match_rs1),
    .o_oitfrd_match_rs2 (w_match_rs2),
    .o_oitfrd_match_rd  (w_match_rd)
  );

  assign io_disp.disp_o_alu_valid = w_alu_valid;
  assign io_disp.disp_i_ready     = io_disp.disp_o_alu_ready & ~w_stall;
  assign io_disp.disp_o_alu_rs1   = w_rs1;
  assign io_disp.disp_o_alu_rs2   = w_rs2;
  assign io_disp.disp_o_alu_rdwen = io_disp.disp_i_rdwen;
  assign io_disp.disp_o_alu_rdidx = io_disp.disp_i_rdidx;
  assign io_disp.disp_o_alu_info  = w_info;
  assign io_disp.disp_o_alu_imm   = io_disp.disp_i_imm;
  assign io_disp.disp_o_alu_pc    = w_pc;
  assign io_disp.disp_o_alu_itag  = w_wr_ptr;
  assign io_disp.oitf_ret_ready   = ~io_disp.oitf_empty;
  assign io_disp.oitf_full        = w_full;
endmodule

// File: tb/tb_exu_disp_oitf.sv
// Bench for exu_disp_oitf: issued long-pipe ops go into a scoreboard queue
// that is popped and compared against the OITF head at each retirement.
module tb_exu_disp_oitf;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  typedef struct {
    logic [IW-1:0] itag;
    logic          rdwen;
    logic [4:0]    rdidx;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_wr = 0;
  int   m_rd = 0;
  sb_t  sb_q[$];
  sb_t  exp_e;

  always #5 clk = ~clk;

  exu_disp_oitf_if #(.XLEN(32), .PC_W(32), .RFIDX_W(5), .INFO_W(32), .ITAG_W(IW)) ifc ();

  exu_disp_oitf dut (
    .clk     (clk),
    .rst     (rst),
    .io_disp (ifc)
  );

  task automatic drive_idle();
    ifc.disp_i_valid = 0; ifc.disp_i_rs1x0 = 0; ifc.disp_i_rs2x0 = 0;
    ifc.disp_i_rs1en = 0; ifc.disp_i_rs2en = 0;
    ifc.disp_i_rs1idx = 0; ifc.disp_i_rs2idx = 0;
    ifc.disp_i_rs1 = 0; ifc.disp_i_rs2 = 0;
    ifc.disp_i_rdwen = 0; ifc.disp_i_rdidx = 0;
    ifc.disp_i_info = 0; ifc.disp_i_imm = 0; ifc.disp_i_pc = 0;
    ifc.disp_o_alu_ready = 1; ifc.disp_o_alu_longpipe = 0;
    ifc.oitf_ret_valid = 0;
  endtask

  task automatic drive_op(input logic lp, input logic rs1en, input logic [4:0] rs1idx,
                          input logic rdwen, input logic [4:0] rdidx);
    ifc.disp_i_valid = 1; ifc.disp_o_alu_longpipe = lp;
    ifc.disp_i_rs1en = rs1en; ifc.disp_i_rs1idx = rs1idx;
    ifc.disp_i_rs2en = 0; ifc.disp_i_rs2idx = 0;
    ifc.disp_i_rdwen = rdwen; ifc.disp_i_rdidx = rdidx;
  endtask

  task automatic pulse_reset();
    drive_idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb_q.delete();
    m_wr = 0;
    m_rd = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    n_tests++; if (ifc.oitf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", ifc.oitf_empty); end
    n_tests++; if (ifc.oitf_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", ifc.oitf_full); end
    n_tests++; if (ifc.oitf_ret_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ret_ready got %b want 0", ifc.oitf_ret_ready); end
    n_tests++; if (ifc.oitf_ret_ptr !== '0) begin n_fail++; $display("FAIL reset_ret_ptr got %0d want 0", ifc.oitf_ret_ptr); end
    n_tests++; if (ifc.disp_o_alu_itag !== '0) begin n_fail++; $display("FAIL reset_itag got %0d want 0", ifc.disp_o_alu_itag); end
  endtask

  task automatic test_independent();
    @(negedge clk);
    drive_op(1'b0, 1'b1, 5'd3, 1'b1, 5'd5);
    ifc.disp_i_rs2en = 1; ifc.disp_i_rs2idx = 5'd4;
    ifc.disp_i_rs1 = 32'h1111_2222; ifc.disp_i_rs2 = 32'h3333_4444;
    ifc.disp_i_imm = 32'h0000_0ABC; ifc.disp_i_pc = 32'h8000_0010; ifc.disp_i_info = 32'h5A5A_0001;
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1) begin n_fail++; $display("FAIL indep_valid got %b want 1", ifc.disp_o_alu_valid); end
    n_tests++; if (ifc.disp_i_ready !== 1'b1) begin n_fail++; $display("FAIL indep_ready got %b want 1", ifc.disp_i_ready); end
    n_tests++; if (ifc.disp_o_alu_rs1 !== 32'h1111_2222) begin n_fail++; $display("FAIL indep_rs1 got %h want 11112222", ifc.disp_o_alu_rs1); end
    n_tests++; if (ifc.disp_o_alu_rs2 !== 32'h3333_4444) begin n_fail++; $display("FAIL indep_rs2 got %h want 33334444", ifc.disp_o_alu_rs2); end
    n_tests++; if (ifc.disp_o_alu_pc !== 32'h8000_0010 || ifc.disp_o_alu_imm !== 32'h0000_0ABC ||
                   ifc.disp_o_alu_info !== 32'h5A5A_0001 || ifc.disp_o_alu_rdidx !== 5'd5 || ifc.disp_o_alu_rdwen !== 1'b1) begin
      n_fail++; $display("FAIL indep_passthru got pc=%h imm=%h info=%h rd=%0d want 80000010 00000abc 5a5a0001 5",
                         ifc.disp_o_alu_pc, ifc.disp_o_alu_imm, ifc.disp_o_alu_info, ifc.disp_o_alu_rdidx);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_tests++; if (ifc.oitf_empty !== 1'b1) begin n_fail++; $display("FAIL indep_empty got %b want 1", ifc.oitf_empty); end
  endtask

  task automatic test_x0_mask();
    @(negedge clk);
    drive_op(1'b0, 1'b1, 5'd0, 1'b0, 5'd0);
    ifc.disp_i_rs1x0 = 1; ifc.disp_i_rs1 = 32'hDEAD_BEEF; ifc.disp_i_rs2 = 32'hCAFE_F00D;
    #1;
    n_tests++; if (ifc.disp_o_alu_rs1 !== 32'h0) begin n_fail++; $display("FAIL x0_rs1 got %h want 0", ifc.disp_o_alu_rs1); end
    n_tests++; if (ifc.disp_o_alu_rs2 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL x0_rs2_keep got %h want cafef00d", ifc.disp_o_alu_rs2); end
    ifc.disp_i_rs1x0 = 0; ifc.disp_i_rs2x0 = 1;
    #1;
    n_tests++; if (ifc.disp_o_alu_rs1 !== 32'hDEAD_BEEF || ifc.disp_o_alu_rs2 !== 32'h0) begin
      n_fail++; $display("FAIL x0_rs2 got rs1=%h rs2=%h want deadbeef 0", ifc.disp_o_alu_rs1, ifc.disp_o_alu_rs2);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_raw_stall();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 5'd0, 1'b1, 5'd7);
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1 || ifc.disp_o_alu_itag !== IW'(m_wr)) begin
      n_fail++; $display("FAIL raw_lp_issue got valid=%b itag=%0d want 1 %0d", ifc.disp_o_alu_valid, ifc.disp_o_alu_itag, m_wr);
    end
    sb_q.push_back('{itag: IW'(m_wr), rdwen: 1'b1, rdidx: 5'd7});
    m_wr = (m_wr + 1) % DEPTH;
    @(negedge clk);
    drive_op(1'b0, 1'b1, 5'd7, 1'b1, 5'd8);
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b0 || ifc.disp_i_ready !== 1'b0) begin
      n_fail++; $display("FAIL raw_stall got valid=%b ready=%b want 0 0", ifc.disp_o_alu_valid, ifc.disp_i_ready);
    end
    n_tests++; if (ifc.oitf_ret_ready !== 1'b1) begin n_fail++; $display("FAIL raw_ret_ready got %b want 1", ifc.oitf_ret_ready); end
    @(negedge clk);
    ifc.oitf_ret_valid = 1;
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b0) begin n_fail++; $display("FAIL raw_same_cycle_ret got valid=%b want 0", ifc.disp_o_alu_valid); end
    if (sb_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL raw_sb_empty got 0 entries want 1"); end
    else begin
      exp_e = sb_q.pop_front();
      n_tests++; if (ifc.oitf_ret_ptr !== exp_e.itag || ifc.oitf_ret_rdidx !== exp_e.rdidx || ifc.oitf_ret_rdwen !== exp_e.rdwen) begin
        n_fail++; $display("FAIL raw_retire got ptr=%0d rd=%0d want %0d %0d", ifc.oitf_ret_ptr, ifc.oitf_ret_rdidx, exp_e.itag, exp_e.rdidx);
      end
    end
    m_rd = (m_rd + 1) % DEPTH;
    @(negedge clk);
    ifc.oitf_ret_valid = 0;
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1 || ifc.disp_i_ready !== 1'b1 || ifc.oitf_empty !== 1'b1) begin
      n_fail++; $display("FAIL raw_release got valid=%b ready=%b empty=%b want 1 1 1", ifc.disp_o_alu_valid, ifc.disp_i_ready, ifc.oitf_empty);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_full_wrap();
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_op(1'b1, 1'b0, 5'd0, 1'b1, 5'(10 + i));
      #1;
      n_tests++; if (ifc.disp_o_alu_valid !== 1'b1 || ifc.disp_o_alu_itag !== IW'(m_wr)) begin
        n_fail++; $display("FAIL fill_issue[%0d] got valid=%b itag=%0d want 1 %0d", i, ifc.disp_o_alu_valid, ifc.disp_o_alu_itag, m_wr);
      end
      sb_q.push_back('{itag: IW'(m_wr), rdwen: 1'b1, rdidx: 5'(10 + i)});
      m_wr = (m_wr + 1) % DEPTH;
      @(negedge clk);
    end
    drive_op(1'b1, 1'b0, 5'd0, 1'b1, 5'd14);
    #1;
    n_tests++; if (ifc.oitf_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", ifc.oitf_full); end
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b0 || ifc.disp_i_ready !== 1'b0) begin
      n_fail++; $display("FAIL fifth_stall got valid=%b ready=%b want 0 0", ifc.disp_o_alu_valid, ifc.disp_i_ready);
    end
    @(negedge clk);
    ifc.oitf_ret_valid = 1;
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b0) begin n_fail++; $display("FAIL fifth_ret_cycle got valid=%b want 0", ifc.disp_o_alu_valid); end
    exp_e = sb_q.pop_front();
    n_tests++; if (ifc.oitf_ret_ptr !== exp_e.itag || ifc.oitf_ret_rdidx !== exp_e.rdidx) begin
      n_fail++; $display("FAIL full_retire got ptr=%0d rd=%0d want %0d %0d", ifc.oitf_ret_ptr, ifc.oitf_ret_rdidx, exp_e.itag, exp_e.rdidx);
    end
    m_rd = (m_rd + 1) % DEPTH;
    @(negedge clk);
    ifc.oitf_ret_valid = 0;
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1 || ifc.disp_o_alu_itag !== IW'(m_wr)) begin
      n_fail++; $display("FAIL fifth_wrap_issue got valid=%b itag=%0d want 1 %0d", ifc.disp_o_alu_valid, ifc.disp_o_alu_itag, m_wr);
    end
    sb_q.push_back('{itag: IW'(m_wr), rdwen: 1'b1, rdidx: 5'd14});
    m_wr = (m_wr + 1) % DEPTH;
    @(negedge clk);
    drive_idle();
    #1;
    n_tests++; if (ifc.oitf_full !== 1'b1 || ifc.oitf_ret_ptr !== IW'(m_rd)) begin
      n_fail++; $display("FAIL wrap_full got full=%b ptr=%0d want 1 %0d", ifc.oitf_full, ifc.oitf_ret_ptr, m_rd);
    end
  endtask

  task automatic test_full_retire_issue();
    drive_op(1'b0, 1'b0, 5'd0, 1'b1, 5'd20);
    ifc.oitf_ret_valid = 1;
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1) begin n_fail++; $display("FAIL full_alu_issue got valid=%b want 1", ifc.disp_o_alu_valid); end
    exp_e = sb_q.pop_front();
    n_tests++; if (ifc.oitf_ret_ptr !== exp_e.itag || ifc.oitf_ret_rdidx !== exp_e.rdidx) begin
      n_fail++; $display("FAIL full_alu_retire got ptr=%0d rd=%0d want %0d %0d", ifc.oitf_ret_ptr, ifc.oitf_ret_rdidx, exp_e.itag, exp_e.rdidx);
    end
    m_rd = (m_rd + 1) % DEPTH;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 5'd0, 1'b1, 5'd21);
    ifc.oitf_ret_valid = 1;
    #1;
    n_tests++; if (ifc.oitf_full !== 1'b0 || ifc.oitf_empty !== 1'b0 || ifc.oitf_ret_ptr !== IW'(m_rd)) begin
      n_fail++; $display("FAIL after_full_ret got full=%b empty=%b ptr=%0d want 0 0 %0d", ifc.oitf_full, ifc.oitf_empty, ifc.oitf_ret_ptr, m_rd);
    end
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1 || ifc.disp_o_alu_itag !== IW'(m_wr)) begin
      n_fail++; $display("FAIL simul_alloc got valid=%b itag=%0d want 1 %0d", ifc.disp_o_alu_valid, ifc.disp_o_alu_itag, m_wr);
    end
    sb_q.push_back('{itag: IW'(m_wr), rdwen: 1'b1, rdidx: 5'd21});
    m_wr = (m_wr + 1) % DEPTH;
    exp_e = sb_q.pop_front();
    n_tests++; if (ifc.oitf_ret_ptr !== exp_e.itag || ifc.oitf_ret_rdidx !== exp_e.rdidx) begin
      n_fail++; $display("FAIL simul_retire got ptr=%0d rd=%0d want %0d %0d", ifc.oitf_ret_ptr, ifc.oitf_ret_rdidx, exp_e.itag, exp_e.rdidx);
    end
    m_rd = (m_rd + 1) % DEPTH;
    @(negedge clk);
    drive_idle();
    #1;
    n_tests++; if (ifc.oitf_full !== 1'b0 || ifc.oitf_empty !== 1'b0 || ifc.oitf_ret_ptr !== IW'(m_rd) || ifc.disp_o_alu_itag !== IW'(m_wr)) begin
      n_fail++; $display("FAIL simul_occupancy got full=%b empty=%b rptr=%0d wptr=%0d want 0 0 %0d %0d",
                         ifc.oitf_full, ifc.oitf_empty, ifc.oitf_ret_ptr, ifc.disp_o_alu_itag, m_rd, m_wr);
    end
  endtask

  task automatic test_reset_midop();
    n_tests++; if (sb_q.size() != 3) begin n_fail++; $display("FAIL midop_pending got %0d want 3", sb_q.size()); end
    pulse_reset();
    #1;
    n_tests++; if (ifc.oitf_empty !== 1'b1 || ifc.oitf_ret_ready !== 1'b0 || ifc.oitf_full !== 1'b0 ||
                   ifc.oitf_ret_ptr !== '0 || ifc.disp_o_alu_itag !== '0) begin
      n_fail++; $display("FAIL midop_reset got empty=%b rdy=%b full=%b rptr=%0d itag=%0d want 1 0 0 0 0",
                         ifc.oitf_empty, ifc.oitf_ret_ready, ifc.oitf_full, ifc.oitf_ret_ptr, ifc.disp_o_alu_itag);
    end
    ifc.oitf_ret_valid = 1;
    @(negedge clk);
    ifc.oitf_ret_valid = 0;
    drive_op(1'b0, 1'b1, 5'd13, 1'b0, 5'd0);
    #1;
    n_tests++; if (ifc.oitf_empty !== 1'b1 || ifc.oitf_ret_ptr !== '0 || ifc.disp_o_alu_itag !== '0) begin
      n_fail++; $display("FAIL empty_ret_ignored got empty=%b rptr=%0d wptr=%0d want 1 0 0", ifc.oitf_empty, ifc.oitf_ret_ptr, ifc.disp_o_alu_itag);
    end
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1) begin n_fail++; $display("FAIL stale_hazard got valid=%b want 1", ifc.disp_o_alu_valid); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_waw();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 5'd0, 1'b1, 5'd9);
    #1;
    n_tests++; if (ifc.disp_o_alu_itag !== IW'(m_wr)) begin n_fail++; $display("FAIL waw_lp_itag got %0d want %0d", ifc.disp_o_alu_itag, m_wr); end
    sb_q.push_back('{itag: IW'(m_wr), rdwen: 1'b1, rdidx: 5'd9});
    m_wr = (m_wr + 1) % DEPTH;
    @(negedge clk);
    drive_op(1'b0, 1'b0, 5'd0, 1'b1, 5'd9);
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b0) begin n_fail++; $display("FAIL waw_stall got valid=%b want 0", ifc.disp_o_alu_valid); end
    ifc.disp_i_rdwen = 0;
    #1;
    n_tests++; if (ifc.disp_o_alu_valid !== 1'b1) begin n_fail++; $display("FAIL waw_nowrite got valid=%b want 1", ifc.disp_o_alu_valid); end
    ifc.disp_i_valid = 0;
    ifc.disp_o_alu_ready = 0;
    ifc.disp_i_rdwen = 1;
    #1;
    n_tests++; if (ifc.disp_i_ready !== 1'b0) begin n_fail++; $display("FAIL waw_ready got %b want 0", ifc.disp_i_ready); end
    @(negedge clk);
    drive_idle();
    ifc.oitf_ret_valid = 1;
    #1;
    exp_e = sb_q.pop_front();
    n_tests++; if (ifc.oitf_ret_ptr !== exp_e.itag || ifc.oitf_ret_rdidx !== exp_e.rdidx) begin
      n_fail++; $display("FAIL waw_retire got ptr=%0d rd=%0d want %0d %0d", ifc.oitf_ret_ptr, ifc.oitf_ret_rdidx, exp_e.itag, exp_e.rdidx);
    end
    m_rd = (m_rd + 1) % DEPTH;
    @(negedge clk);
    drive_idle();
    #1;
    n_tests++; if (ifc.oitf_empty !== 1'b1 || ifc.oitf_ret_ptr !== IW'(m_rd)) begin
      n_fail++; $display("FAIL waw_final got empty=%b ptr=%0d want 1 %0d", ifc.oitf_empty, ifc.oitf_ret_ptr, m_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_independent();
    test_x0_mask();
    test_raw_stall();
    test_full_wrap();
    test_full_retire_issue();
    test_reset_midop();
    test_waw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
